// File: rtl/conv_param_scheduler.sv
// conv_param_scheduler: streams the weight and bias words of one convolution layer, one output-channel
// tile after another, and replays the full set once per image.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, num_images     start a layer and give its image count (sampled only in idle)
//   busy, done            layer in progress, one-cycle completion pulse
//   w_mem_*               weight memory read port (1-cycle read latency)
//   b_mem_*               bias memory read port (1-cycle read latency)
//   weight/_valid/_ready  weight beat stream, unpacked from one memory word
//   bias/_valid/_ready    bias beat stream, unpacked from one memory word
module conv_param_scheduler #(
  parameter int unsigned W_WIDTH           = 8,
  parameter int unsigned BIAS_WIDTH        = 8,
  parameter int unsigned KERNEL_X          = 2,
  parameter int unsigned KERNEL_Y          = 2,
  parameter int unsigned IN_C              = 4,
  parameter int unsigned OUT_C             = 4,
  parameter int unsigned UNROLL_KERNEL_OUT = 4,
  parameter int unsigned UNROLL_OUT_C      = 2,
  parameter int unsigned IMG_CNT_WIDTH     = 8,
  localparam int unsigned W_DEPTH   = KERNEL_Y * KERNEL_X * IN_C / UNROLL_KERNEL_OUT,
  localparam int unsigned OUT_TILES = OUT_C / UNROLL_OUT_C,
  localparam int unsigned W_WORDS   = W_DEPTH * OUT_TILES,
  localparam int unsigned W_AW      = (W_WORDS > 1) ? $clog2(W_WORDS) : 1,
  localparam int unsigned B_AW      = (OUT_TILES > 1) ? $clog2(OUT_TILES) : 1,
  localparam int unsigned W_ELEMS   = UNROLL_KERNEL_OUT * UNROLL_OUT_C,
  localparam int unsigned W_BITS    = W_ELEMS * W_WIDTH,
  localparam int unsigned B_BITS    = UNROLL_OUT_C * BIAS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IMG_CNT_WIDTH-1:0] num_images,
  output logic                     busy,
  output logic                     done,
  output logic                     w_mem_rd_en,
  output logic [W_AW-1:0]          w_mem_addr,
  input  logic [W_BITS-1:0]        w_mem_rdata,
  output logic                     b_mem_rd_en,
  output logic [B_AW-1:0]          b_mem_addr,
  input  logic [B_BITS-1:0]        b_mem_rdata,
  output logic [W_WIDTH-1:0]       weight [W_ELEMS],
  output logic                     weight_valid,
  input  logic                     weight_ready,
  output logic [BIAS_WIDTH-1:0]    bias [UNROLL_OUT_C],
  output logic                     bias_valid,
  input  logic                     bias_ready
);

  localparam logic [W_AW-1:0] W_LAST = W_AW'(W_WORDS - 1);
  localparam logic [B_AW-1:0] B_LAST = B_AW'(OUT_TILES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                   state_q, state_d;
  logic [IMG_CNT_WIDTH-1:0] num_q;
  logic                     zero_done_q;
  logic                     start_run;
  logic                     drained;

  // Weight stream: address/image counters, in-flight flag, 2-entry FIFO.
  logic [W_AW-1:0]          w_addr_q;
  logic [IMG_CNT_WIDTH-1:0] w_img_q;
  logic                     w_issue_done;
  logic                     w_inflight_q;
  logic [W_BITS-1:0]        w_fifo_q [2];
  logic                     w_wptr_q, w_rptr_q;
  logic [1:0]               w_cnt_q, w_cnt_d;
  logic                     w_pop;

  // Bias stream: same structure.
  logic [B_AW-1:0]          b_addr_q;
  logic [IMG_CNT_WIDTH-1:0] b_img_q;
  logic                     b_issue_done;
  logic                     b_inflight_q;
  logic [B_BITS-1:0]        b_fifo_q [2];
  logic                     b_wptr_q, b_rptr_q;
  logic [1:0]               b_cnt_q, b_cnt_d;
  logic                     b_pop;

  assign start_run    = (state_q == StIdle) && start && (num_images != '0);
  // The image counter only reaches num_q, so it never wraps even at the maximum count.
  assign w_issue_done = (w_img_q == num_q);
  assign b_issue_done = (b_img_q == num_q);
  assign drained      = (w_cnt_q == 2'd0) && !w_inflight_q && (b_cnt_q == 2'd0) && !b_inflight_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_run) state_d = StRun;
      StRun:   if (w_issue_done && b_issue_done) state_d = StDrain;
      StDrain: if (drained) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = zero_done_q || ((state_q == StDrain) && drained);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      if (start_run) num_q <= num_images;
      zero_done_q <= (state_q == StIdle) && start && (num_images == '0);
    end
  end

  // Occupancy after this cycle's push/pop. Using it (rather than the registered count) as the
  // read credit lets a pop free a slot in the same cycle, which keeps one beat per cycle.
  assign w_pop       = weight_valid && weight_ready;
  assign w_cnt_d     = w_cnt_q + {1'b0, w_inflight_q} - {1'b0, w_pop};
  assign w_mem_rd_en = (state_q == StRun) && !w_issue_done && (w_cnt_d < 2'd2);
  assign w_mem_addr  = w_addr_q;

  assign b_pop       = bias_valid && bias_ready;
  assign b_cnt_d     = b_cnt_q + {1'b0, b_inflight_q} - {1'b0, b_pop};
  assign b_mem_rd_en = (state_q == StRun) && !b_issue_done && (b_cnt_d < 2'd2);
  assign b_mem_addr  = b_addr_q;

  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      w_addr_q <= '0;
      w_img_q  <= '0;
    end else if (w_mem_rd_en) begin
      if (w_addr_q == W_LAST) begin
        w_addr_q <= '0;
        w_img_q  <= w_img_q + 1'b1;
      end else begin
        w_addr_q <= w_addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      b_addr_q <= '0;
      b_img_q  <= '0;
    end else if (b_mem_rd_en) begin
      if (b_addr_q == B_LAST) begin
        b_addr_q <= '0;
        b_img_q  <= b_img_q + 1'b1;
      end else begin
        b_addr_q <= b_addr_q + 1'b1;
      end
    end
  end

  // Read data returns the cycle after rd_en and is pushed straight into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_inflight_q <= 1'b0;
      w_wptr_q     <= 1'b0;
      w_rptr_q     <= 1'b0;
      w_cnt_q      <= 2'd0;
      w_fifo_q[0]  <= '0;
      w_fifo_q[1]  <= '0;
    end else begin
      w_inflight_q <= w_mem_rd_en;
      if (w_inflight_q) begin
        w_fifo_q[w_wptr_q] <= w_mem_rdata;
        w_wptr_q           <= ~w_wptr_q;
      end
      if (w_pop) w_rptr_q <= ~w_rptr_q;
      w_cnt_q <= w_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_inflight_q <= 1'b0;
      b_wptr_q     <= 1'b0;
      b_rptr_q     <= 1'b0;
      b_cnt_q      <= 2'd0;
      b_fifo_q[0]  <= '0;
      b_fifo_q[1]  <= '0;
    end else begin
      b_inflight_q <= b_mem_rd_en;
      if (b_inflight_q) begin
        b_fifo_q[b_wptr_q] <= b_mem_rdata;
        b_wptr_q           <= ~b_wptr_q;
      end
      if (b_pop) b_rptr_q <= ~b_rptr_q;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign weight_valid = (w_cnt_q != 2'd0);
  assign bias_valid   = (b_cnt_q != 2'd0);

  always_comb begin
    for (int unsigned i = 0; i < W_ELEMS; i++) begin
      weight[i] = w_fifo_q[w_rptr_q][i*W_WIDTH +: W_WIDTH];
    end
    for (int unsigned i = 0; i < UNROLL_OUT_C; i++) begin
      bias[i] = b_fifo_q[b_rptr_q][i*BIAS_WIDTH +: BIAS_WIDTH];
    end
  end

endmodule
